// File: rtl/control.sv
// control: Moore control FSM for the LC-3b multicycle core (fetch, decode, execute).
// Optional feature macro: CONTROL_LEA_EN adds the S_LEA state; without it LEA decodes as unsupported.
module control (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] opcode,
  input  logic       branch_enable,
  input  logic       mem_resp,
  output logic       load_pc,
  output logic       load_ir,
  output logic       load_regfile,
  output logic       load_mar,
  output logic       load_mdr,
  output logic       load_cc,
  output logic       pcmux_sel,
  output logic       storemux_sel,
  output logic       alumux_sel,
  output logic       marmux_sel,
  output logic       mdrmux_sel,
  output logic [1:0] regfilemux_sel,
  output logic [2:0] aluop,
  output logic       mem_read,
  output logic       mem_write,
  output logic [1:0] mem_byte_enable
);

  localparam logic [3:0] OP_BR  = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_AND = 4'b0101;
  localparam logic [3:0] OP_LDR = 4'b0110;
  localparam logic [3:0] OP_STR = 4'b0111;
  localparam logic [3:0] OP_NOT = 4'b1001;
`ifdef CONTROL_LEA_EN
  localparam logic [3:0] OP_LEA = 4'b1110;
`endif

  localparam logic [2:0] ALU_ADD  = 3'd0;
  localparam logic [2:0] ALU_AND  = 3'd1;
  localparam logic [2:0] ALU_NOT  = 3'd2;
  localparam logic [2:0] ALU_PASS = 3'd3;

  typedef enum logic [3:0] {
    FETCH1, FETCH2, FETCH3, DECODE,
    S_ADD, S_AND, S_NOT,
    BR, BR_TAKEN,
    CALC_ADDR, LDR1, LDR2, STR1, STR2
`ifdef CONTROL_LEA_EN
    , S_LEA
`endif
  } state_e;

  typedef struct packed {
    logic       load_pc;
    logic       load_ir;
    logic       load_regfile;
    logic       load_mar;
    logic       load_mdr;
    logic       load_cc;
    logic       pcmux_sel;
    logic       storemux_sel;
    logic       alumux_sel;
    logic       marmux_sel;
    logic       mdrmux_sel;
    logic [1:0] regfilemux_sel;
    logic [2:0] aluop;
    logic       mem_read;
    logic       mem_write;
    logic [1:0] mem_byte_enable;
  } ctrl_t;

  state_e state_q, state_d;
  ctrl_t  ctrl_q;

  // Moore output decode; registered against the next state so outputs track state_q exactly.
  function automatic ctrl_t decode_state(input state_e s);
    ctrl_t c;
    c                 = '0;
    c.aluop           = ALU_ADD;
    c.mem_byte_enable = 2'b11;
    case (s)
      FETCH1:    begin c.load_mar = 1'b1; c.marmux_sel = 1'b1; end
      FETCH2:    begin c.mem_read = 1'b1; c.mdrmux_sel = 1'b1; c.load_mdr = 1'b1; end
      FETCH3:    begin c.load_ir = 1'b1; c.load_pc = 1'b1; end
      S_ADD:     begin c.aluop = ALU_ADD; c.load_regfile = 1'b1; c.load_cc = 1'b1; end
      S_AND:     begin c.aluop = ALU_AND; c.load_regfile = 1'b1; c.load_cc = 1'b1; end
      S_NOT:     begin c.aluop = ALU_NOT; c.load_regfile = 1'b1; c.load_cc = 1'b1; end
      BR_TAKEN:  begin c.pcmux_sel = 1'b1; c.load_pc = 1'b1; end
      CALC_ADDR: begin c.alumux_sel = 1'b1; c.load_mar = 1'b1; end
      LDR1:      begin c.mem_read = 1'b1; c.mdrmux_sel = 1'b1; c.load_mdr = 1'b1; end
      LDR2:      begin c.regfilemux_sel = 2'd1; c.load_regfile = 1'b1; c.load_cc = 1'b1; end
      STR1:      begin c.storemux_sel = 1'b1; c.aluop = ALU_PASS; c.load_mdr = 1'b1; end
      STR2:      begin c.mem_write = 1'b1; end
`ifdef CONTROL_LEA_EN
      S_LEA:     begin c.regfilemux_sel = 2'd2; c.load_regfile = 1'b1; c.load_cc = 1'b1; end
`endif
      default:   begin c.load_pc = 1'b0; end
    endcase
    return c;
  endfunction

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH1: state_d = FETCH2;
      FETCH2: begin
        if (mem_resp) state_d = FETCH3;
        else          state_d = FETCH2;
      end
      FETCH3: state_d = DECODE;
      DECODE: begin
        case (opcode)
          OP_ADD:  state_d = S_ADD;
          OP_AND:  state_d = S_AND;
          OP_NOT:  state_d = S_NOT;
          OP_BR:   state_d = BR;
          OP_LDR:  state_d = CALC_ADDR;
          OP_STR:  state_d = CALC_ADDR;
`ifdef CONTROL_LEA_EN
          OP_LEA:  state_d = S_LEA;
`endif
          default: state_d = FETCH1;
        endcase
      end
      BR: begin
        if (branch_enable) state_d = BR_TAKEN;
        else               state_d = FETCH1;
      end
      CALC_ADDR: begin
        if (opcode == OP_LDR) state_d = LDR1;
        else                  state_d = STR1;
      end
      LDR1: begin
        if (mem_resp) state_d = LDR2;
        else          state_d = LDR1;
      end
      STR1: state_d = STR2;
      STR2: begin
        if (mem_resp) state_d = FETCH1;
        else          state_d = STR2;
      end
      default: state_d = FETCH1;
    endcase
  end

  // State and output registers; reset lands in FETCH1 and drops memory strobes immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= FETCH1;
      ctrl_q  <= decode_state(FETCH1);
    end else begin
      state_q <= state_d;
      ctrl_q  <= decode_state(state_d);
    end
  end

  assign load_pc         = ctrl_q.load_pc;
  assign load_ir         = ctrl_q.load_ir;
  assign load_regfile    = ctrl_q.load_regfile;
  assign load_mar        = ctrl_q.load_mar;
  assign load_mdr        = ctrl_q.load_mdr;
  assign load_cc         = ctrl_q.load_cc;
  assign pcmux_sel       = ctrl_q.pcmux_sel;
  assign storemux_sel    = ctrl_q.storemux_sel;
  assign alumux_sel      = ctrl_q.alumux_sel;
  assign marmux_sel      = ctrl_q.marmux_sel;
  assign mdrmux_sel      = ctrl_q.mdrmux_sel;
  assign regfilemux_sel  = ctrl_q.regfilemux_sel;
  assign aluop           = ctrl_q.aluop;
  assign mem_read        = ctrl_q.mem_read;
  assign mem_write       = ctrl_q.mem_write;
  assign mem_byte_enable = ctrl_q.mem_byte_enable;

endmodule

// File: tb/tb_control.sv
// tb_control: randomized instruction stream against a per-instruction cycle-plan model of the
// LC-3b control FSM, plus cycles-per-instruction and asynchronous reset checks.
module tb_control;

  typedef struct packed {
    logic       load_pc;
    logic       load_ir;
    logic       load_regfile;
    logic       load_mar;
    logic       load_mdr;
    logic       load_cc;
    logic       pcmux_sel;
    logic       storemux_sel;
    logic       alumux_sel;
    logic       marmux_sel;
    logic       mdrmux_sel;
    logic [1:0] regfilemux_sel;
    logic [2:0] aluop;
    logic       mem_read;
    logic       mem_write;
    logic [1:0] mem_byte_enable;
  } vec_t;

  typedef struct packed {
    vec_t       exp;
    logic [3:0] op;
    logic       be;
    logic       resp;
  } step_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] opcode;
  logic       branch_enable;
  logic       mem_resp;
  logic       load_pc, load_ir, load_regfile, load_mar, load_mdr, load_cc;
  logic       pcmux_sel, storemux_sel, alumux_sel, marmux_sel, mdrmux_sel;
  logic [1:0] regfilemux_sel;
  logic [2:0] aluop;
  logic       mem_read, mem_write;
  logic [1:0] mem_byte_enable;
  vec_t       obs;

  int pass_cnt = 0;
  int total_cnt = 0;
  int cyc = 0;
  int since_fetch = 0;
  bit started = 1'b0;
  step_t plan[$];
  int    cpi_q[$];

  control dut (
    .clk(clk), .reset(reset), .opcode(opcode), .branch_enable(branch_enable),
    .mem_resp(mem_resp), .load_pc(load_pc), .load_ir(load_ir),
    .load_regfile(load_regfile), .load_mar(load_mar), .load_mdr(load_mdr),
    .load_cc(load_cc), .pcmux_sel(pcmux_sel), .storemux_sel(storemux_sel),
    .alumux_sel(alumux_sel), .marmux_sel(marmux_sel), .mdrmux_sel(mdrmux_sel),
    .regfilemux_sel(regfilemux_sel), .aluop(aluop), .mem_read(mem_read),
    .mem_write(mem_write), .mem_byte_enable(mem_byte_enable)
  );

  assign obs = {load_pc, load_ir, load_regfile, load_mar, load_mdr, load_cc,
                pcmux_sel, storemux_sel, alumux_sel, marmux_sel, mdrmux_sel,
                regfilemux_sel, aluop, mem_read, mem_write, mem_byte_enable};

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  function automatic logic rnd1();
    return logic'($urandom_range(0, 1));
  endfunction

  function automatic logic [3:0] rnd4();
    return 4'($urandom_range(0, 15));
  endfunction

  function automatic vec_t idle();
    vec_t v;
    v = '0;
    v.mem_byte_enable = 2'b11;
    return v;
  endfunction

  function automatic vec_t fetch1();
    vec_t v;
    v = idle();
    v.load_mar = 1'b1;
    v.marmux_sel = 1'b1;
    return v;
  endfunction

  // 0 = ALU op, 1 = BR, 2 = LDR/STR, 3 = LEA (when built in), 4 = unsupported
  function automatic int classify(input logic [3:0] op);
    case (op)
      4'b0001, 4'b0101, 4'b1001: return 0;
      4'b0000:                   return 1;
      4'b0110, 4'b0111:          return 2;
`ifdef CONTROL_LEA_EN
      4'b1110:                   return 3;
`endif
      default:                   return 4;
    endcase
  endfunction

  task automatic push(input vec_t e, input logic [3:0] op, input logic be, input logic resp);
    step_t s;
    s.exp = e; s.op = op; s.be = be; s.resp = resp;
    plan.push_back(s);
  endtask

  task automatic add_wait(input vec_t e, input int d, input logic [3:0] op);
    for (int i = 0; i < d; i++) push(e, op, rnd1(), 1'b0);
    push(e, op, rnd1(), 1'b1);
  endtask

  // Append the expected cycle-by-cycle behaviour of one instruction and its expected length.
  task automatic gen(input logic [3:0] op, input logic taken, input int df, input int dm);
    vec_t v;
    int   cls;
    int   cpi;
    cls = classify(op);
    case (cls)
      0:       cpi = 5;
      1:       cpi = taken ? 6 : 5;
      2:       cpi = 7 + dm;
      3:       cpi = 5;
      default: cpi = 4;
    endcase
    cpi_q.push_back(cpi + df);

    push(fetch1(), rnd4(), rnd1(), rnd1());
    v = idle(); v.mem_read = 1'b1; v.mdrmux_sel = 1'b1; v.load_mdr = 1'b1;
    add_wait(v, df, rnd4());
    v = idle(); v.load_ir = 1'b1; v.load_pc = 1'b1;
    push(v, rnd4(), rnd1(), rnd1());
    push(idle(), op, rnd1(), rnd1());
    case (cls)
      0: begin
        v = idle(); v.load_regfile = 1'b1; v.load_cc = 1'b1;
        v.aluop = (op == 4'b0001) ? 3'd0 : ((op == 4'b0101) ? 3'd1 : 3'd2);
        push(v, op, rnd1(), rnd1());
      end
      1: begin
        push(idle(), op, taken, rnd1());
        if (taken) begin
          v = idle(); v.pcmux_sel = 1'b1; v.load_pc = 1'b1;
          push(v, op, rnd1(), rnd1());
        end
      end
      2: begin
        v = idle(); v.alumux_sel = 1'b1; v.load_mar = 1'b1;
        push(v, op, rnd1(), rnd1());
        if (op == 4'b0110) begin
          v = idle(); v.mem_read = 1'b1; v.mdrmux_sel = 1'b1; v.load_mdr = 1'b1;
          add_wait(v, dm, op);
          v = idle(); v.regfilemux_sel = 2'd1; v.load_regfile = 1'b1; v.load_cc = 1'b1;
          push(v, op, rnd1(), rnd1());
        end else begin
          v = idle(); v.storemux_sel = 1'b1; v.aluop = 3'd3; v.load_mdr = 1'b1;
          push(v, op, rnd1(), rnd1());
          v = idle(); v.mem_write = 1'b1;
          add_wait(v, dm, op);
        end
      end
      3: begin
        v = idle(); v.regfilemux_sel = 2'd2; v.load_regfile = 1'b1; v.load_cc = 1'b1;
        push(v, op, rnd1(), rnd1());
      end
      default: begin
      end
    endcase
  endtask

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    total_cnt++;
    assert (o === e) pass_cnt++;
    else $error("FAIL %s: observed %h expected %h", tag, o, e);
  endtask

  // Drive one planned cycle at the falling edge, check it, and track instruction length.
  task automatic run_step(input step_t s);
    opcode = s.op; branch_enable = s.be; mem_resp = s.resp;
    #1;
    chk($sformatf("cycle%0d_outputs", cyc), 32'(obs), 32'(s.exp));
    if (obs.load_mar && obs.marmux_sel && !obs.alumux_sel) begin
      if (started && cpi_q.size() > 0)
        chk($sformatf("cycle%0d_cpi", cyc), 32'(since_fetch), 32'(cpi_q.pop_front()));
      started = 1'b1;
      since_fetch = 1;
    end else begin
      since_fetch++;
    end
    cyc++;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; opcode = 4'd0; branch_enable = 1'b0; mem_resp = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_state", 32'(obs), 32'(fetch1()));
    reset = 1'b0;

    // Reset while FETCH2 is waiting on memory.
    push(fetch1(), rnd4(), 1'b0, 1'b0);
    run_step(plan.pop_front());
    mem_resp = 1'b0;
    #1;
    chk("fetch2_mem_read", 32'(mem_read), 32'(1'b1));
    #1 reset = 1'b1;
    #1;
    chk("async_reset_mem_read", 32'(mem_read), 32'(1'b0));
    chk("async_reset_outputs", 32'(obs), 32'(fetch1()));
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("post_reset_fetch1", 32'(obs), 32'(fetch1()));
    started = 1'b0;

    gen(4'b0001, 1'b0, 0, 0);  // ADD
    gen(4'b0110, 1'b0, 0, 3);  // LDR, slow memory
    gen(4'b0111, 1'b0, 1, 2);  // STR
    gen(4'b0000, 1'b1, 0, 0);  // BR taken
    gen(4'b0000, 1'b0, 0, 0);  // BR not taken
    gen(4'b1110, 1'b0, 0, 0);  // LEA
    gen(4'b0101, 1'b0, 2, 0);  // AND
    gen(4'b1001, 1'b0, 0, 0);  // NOT
    gen(4'b0011, 1'b0, 0, 0);  // unsupported
    for (int i = 0; i < 150; i++)
      gen(rnd4(), rnd1(), $urandom_range(0, 3), $urandom_range(0, 3));
    push(fetch1(), rnd4(), rnd1(), rnd1());

    while (plan.size() > 0) run_step(plan.pop_front());

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/control.md
# control

Moore-style control FSM for the LC-3b multicycle core. It consumes the opcode decoded by the datapath's IR plus memory and branch status, and it drives every load enable, mux select, ALU op and memory strobe of the datapath. It sequences fetch, decode and execute for ADD, AND, NOT, BR, LDR and STR, plus LEA when configured in. One instruction completes before the next fetch begins.

## Interface
- Parameters: none.
- clk  input  1  system clock; all state updates on rising edge
- reset  input  1  asynchronous, active-high; forces state FETCH1
- opcode  input  4  lc3b_opcode from IR; valid from DECODE onward
- branch_enable  input  1  NZP match from CC logic; sampled in BR
- mem_resp  input  1  memory completion for the current read/write
- load_pc, load_ir, load_regfile, load_mar, load_mdr, load_cc  output  1 each  register load enables
- pcmux_sel  output  1  0 = PC+2, 1 = branch adder
- storemux_sel  output  1  0 = sr1 field, 1 = dest field as regfile src_a
- alumux_sel  output  1  0 = reg_b, 1 = adj6 offset
- marmux_sel  output  1  0 = ALU out, 1 = PC
- mdrmux_sel  output  1  0 = ALU out, 1 = mem_rdata
- regfilemux_sel  output  2  0 = ALU out, 1 = MDR, 2 = branch adder (LEA), 3 unused
- aluop  output  3  lc3b_aluop: add, and, not, pass
- mem_read, mem_write  output  1 each  memory strobes
- mem_byte_enable  output  2  constant 2'b11

## Operation
- Outputs are a pure function of state. Every output is 0 unless listed for the state.
- aluop defaults to add.
- FETCH1: load_mar, marmux_sel=1. Next state: FETCH2.
- FETCH2: mem_read, mdrmux_sel=1, load_mdr. Hold while mem_resp=0. Next state: FETCH3.
- FETCH3: load_ir, load_pc, pcmux_sel=0. Next state: DECODE.
- DECODE: no loads. Next state by opcode:
  - ADD→S_ADD, AND→S_AND, NOT→S_NOT
  - BR→BR
  - LDR, STR→CALC_ADDR
  - LEA→S_LEA (macro only)
  - any other opcode→FETCH1, with no architectural side effect
- S_ADD / S_AND / S_NOT: aluop add/and/not, load_regfile, regfilemux_sel=0, load_cc. Next state: FETCH1.
- BR: no loads. branch_enable=1→BR_TAKEN; otherwise FETCH1.
- BR_TAKEN: pcmux_sel=1, load_pc. Next state: FETCH1.
- CALC_ADDR: alumux_sel=1, aluop add, marmux_sel=0, load_mar. Next state: LDR1 if opcode is LDR, else STR1.
- LDR1: mem_read, mdrmux_sel=1, load_mdr. Hold until mem_resp. Next state: LDR2.
- LDR2: regfilemux_sel=1, load_regfile, load_cc. Next state: FETCH1.
- STR1: storemux_sel=1, aluop pass, mdrmux_sel=0, load_mdr. Next state: STR2.
- STR2: mem_write. Hold until mem_resp. Next state: FETCH1.
- mem_resp in any non-waiting state is ignored.
- A mem_resp held high across a state change is treated as a fresh response in the next waiting state; memory deasserts it after one cycle.

## Timing
- Reset outputs equal the FETCH1 decode: load_mar=1, marmux_sel=1, mem_byte_enable=2'b11, all others 0.
- Reset mid-operation (e.g. in FETCH2 or STR2) drops mem_read/mem_write in the same cycle, asynchronously.
- Cycles per instruction with mem_resp in the first wait cycle:
  - ADD/AND/NOT: 5
  - BR not taken: 5; BR taken: 6
  - LDR, STR: 7
  - unsupported opcode: 4
  - LEA: 5
- Each memory wait cycle adds 1.
- Datapath loads occur on the rising edge that leaves the state asserting them.

## Configuration
- CONTROL_LEA_EN defined: S_LEA is present. It asserts regfilemux_sel=2, load_regfile, load_cc, then goes to FETCH1. This writes dest ← PC + (offset9<<1).
- CONTROL_LEA_EN undefined: LEA decodes as unsupported (DECODE→FETCH1). regfilemux_sel never leaves {0,1}.

## Test plan
- Reset asserted in FETCH2 with mem_read=1 → mem_read=0 immediately. After release, FETCH1 outputs appear, then load_mar and marmux_sel=1.
- ADD opcode 4'b0001, mem_resp on the 1st FETCH2 cycle → load_ir on cycle 3 and load_regfile+load_cc on cycle 5 with aluop=add, then FETCH1.
- LDR with mem_resp delayed 3 cycles in LDR1 → mem_read held 4 cycles, then regfilemux_sel=1 with load_regfile; total 10 cycles.
- STR → STR1 shows storemux_sel=1, aluop=pass, load_mdr. mem_write is held until mem_resp, then FETCH1.
- BR with branch_enable=1 → BR_TAKEN with pcmux_sel=1, load_pc (6 cycles). With branch_enable=0 → 5 cycles and no load_pc after FETCH3.
- LEA 4'b1110 → with CONTROL_LEA_EN, regfilemux_sel=2 and load_regfile in cycle 5. Without it, no load_regfile and FETCH1 in cycle 5.
